// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the digital lock sequencer.
//   - lock_state_e : controller states
//   - DIGIT_W      : width of one keypad digit
//   - code_width() : total code width for a given digit count
package lock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } lock_state_e;

  function automatic int code_width(input int code_len);
    return code_len * DIGIT_W;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the OPEN and LOCKOUT windows.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load i_load_val this edge (wins over counting)
//   i_load_val       value to load
//   o_value          current count
//   o_done           count has reached zero
module lock_timer #(
  parameter int MAX_CNT = 16,
  parameter int W       = $clog2(MAX_CNT + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_done
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst)                r_value <= '0;
    else if (i_load)          r_value <= i_load_val;
    else if (r_value != '0)   r_value <= r_value - 1'b1;
  end

  assign o_value = r_value;
  assign o_done  = (r_value == '0);

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: collects CODE_LEN digits, compares against the code
// register, holds unlock for UNLOCK_CYCLES on a match and enters a timed
// lockout after MAX_FAIL consecutive mismatches.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   digit_in, digit_valid  digit and its one-cycle strobe
//   clear                  abort entry / relock early (ignored in lockout)
//   unlock                 lock open (state OPEN)
//   error                  one-cycle mismatch pulse (during CHECK)
//   locked_out             state LOCKOUT
//   busy                   digits are being ignored (CHECK/OPEN/LOCKOUT)
//   fail_cnt               consecutive failure count
//   prog_valid, prog_code  code reprogramming while OPEN
// Build option: define LOCK_CODE_PROG_EN to add the prog_* ports and make
// the code register writable; otherwise the code is fixed at DEFAULT_CODE.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                         CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int                         UNLOCK_CYCLES  = 8,
  parameter int                         MAX_FAIL       = 3,
  parameter int                         LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIGIT_W-1:0]             digit_in,
  input  logic                           digit_valid,
  input  logic                           clear,
`ifdef LOCK_CODE_PROG_EN
  input  logic                           prog_valid,
  input  logic [CODE_LEN*DIGIT_W-1:0]    prog_code,
`endif
  output logic                           unlock,
  output logic                           error,
  output logic                           locked_out,
  output logic                           busy,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

  localparam int CODE_W  = code_width(CODE_LEN);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int ENT_W   = $clog2(CODE_LEN + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  lock_state_e       r_state, w_next;
  logic [CODE_W-1:0] r_entry;
  logic [ENT_W-1:0]  r_entry_cnt;
  logic [FAIL_W-1:0] r_fail;
  logic              r_busy;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_entry_shift;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              w_accept;
  logic              w_match;
  logic              w_error;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic [TMR_W-1:0]  w_tmr_value;
  logic              w_tmr_done;

  // Timer is loaded with N-1 so the state it guards lasts exactly N cycles.
  lock_timer #(.MAX_CNT(TMR_MAX), .W(TMR_W)) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_value    (w_tmr_value),
    .o_done     (w_tmr_done)
  );

  // A digit is only taken while collecting, and clear always drops it.
  assign w_accept      = digit_valid && !clear &&
                         (r_state == S_IDLE || r_state == S_ENTRY);
  assign w_entry_shift = (r_entry << DIGIT_W) | CODE_W'(digit_in);
  assign w_match       = (r_entry == w_code);
  assign w_fail_inc    = r_fail + 1'b1;

  always_comb begin
    w_next     = r_state;
    w_error    = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
      end
      S_ENTRY: begin
        if (clear)
          w_next = S_IDLE;
        else if (w_accept && r_entry_cnt == ENT_W'(CODE_LEN - 1))
          w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_match) begin
          w_next     = S_OPEN;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          w_error = 1'b1;
          if (w_fail_inc >= FAIL_W'(MAX_FAIL)) begin
            w_next     = S_LOCKOUT;
            w_tmr_load = 1'b1;
            w_tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_OPEN:    if (clear || w_tmr_done) w_next = S_IDLE;
      S_LOCKOUT: if (w_tmr_done)          w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_entry     <= '0;
      r_entry_cnt <= '0;
      r_fail      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_CHECK) || (w_next == S_OPEN) || (w_next == S_LOCKOUT);

      // Entry is wiped on every return to IDLE so stale digits never match.
      if (w_next == S_IDLE) begin
        r_entry     <= '0;
        r_entry_cnt <= '0;
      end else if (w_accept) begin
        r_entry     <= w_entry_shift;
        r_entry_cnt <= r_entry_cnt + 1'b1;
      end

      if (r_state == S_CHECK)
        r_fail <= w_match ? '0 : w_fail_inc;
      else if (r_state == S_LOCKOUT && w_tmr_done)
        r_fail <= '0;
    end
  end

`ifdef LOCK_CODE_PROG_EN
  logic [CODE_W-1:0] r_code;

  always_ff @(posedge clk) begin
    if (rst)                                 r_code <= DEFAULT_CODE;
    else if (r_state == S_OPEN && prog_valid) r_code <= prog_code;
  end

  assign w_code = r_code;
`else
  assign w_code = DEFAULT_CODE;
`endif

  // While OPEN the timer can never hold more than the unlock window.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_OPEN)
      assert (w_tmr_value < TMR_W'(UNLOCK_CYCLES));
  end

  assign unlock     = (r_state == S_OPEN);
  assign locked_out = (r_state == S_LOCKOUT);
  assign error      = w_error;
  assign busy       = r_busy;
  assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed vector table for lock_sequencer (default
// parameters) plus hand-written sequences for unlock latency/width and,
// with LOCK_CODE_PROG_EN, code reprogramming.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] din = 4'd0;
  logic       u, e, lo, b;
  logic [1:0] f;
`ifdef LOCK_CODE_PROG_EN
  logic        pv = 1'b0;
  logic [15:0] pc = 16'h0;
`endif

  lock_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (din),
    .digit_valid (dv),
    .clear       (clr),
`ifdef LOCK_CODE_PROG_EN
    .prog_valid  (pv),
    .prog_code   (pc),
`endif
    .unlock      (u),
    .error       (e),
    .locked_out  (lo),
    .busy        (b),
    .fail_cnt    (f)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // x = {unlock, error, locked_out, busy, fail_cnt[1:0]} after the edge
  typedef struct {
    logic       r;
    logic       dv;
    logic [3:0] d;
    logic       c;
    logic [5:0] x;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input logic [3:0] d, input logic c,
                     input logic xu, input logic xe, input logic xl, input logic xb,
                     input logic [1:0] xf);
    vec_t t;
    t.r = r; t.dv = v; t.d = d; t.c = c; t.x = {xu, xe, xl, xb, xf};
    vq.push_back(t);
  endtask

  task automatic idl(input int n, input logic xu, input logic xe, input logic xl,
                     input logic xb, input logic [1:0] xf);
    for (int i = 0; i < n; i++) add(0, 0, 4'd0, 0, xu, xe, xl, xb, xf);
  endtask

  // Four digits; the last vector observes CHECK (error set on mismatch).
  task automatic code4(input logic [3:0] a, input logic [3:0] bb, input logic [3:0] c,
                       input logic [3:0] d, input logic m, input logic [1:0] xf);
    add(0, 1, a,  0, 0, 0, 0, 0, xf);
    add(0, 1, bb, 0, 0, 0, 0, 0, xf);
    add(0, 1, c,  0, 0, 0, 0, 0, xf);
    add(0, 1, d,  0, 0, !m, 0, 1, xf);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    dv = 1'b1; din = d;
    step();
    dv = 1'b0; din = 4'd0;
  endtask

  // Enter a code; report error seen in CHECK and unlock on the next cycle.
  task automatic run_code(input logic [3:0] a, input logic [3:0] bb, input logic [3:0] c,
                          input logic [3:0] d, output logic got_e, output logic got_u);
    digit(a); digit(bb); digit(c); digit(d);
    got_e = e;
    step();
    got_u = u;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (b !== 1'b0 && k < 40) begin step(); k++; end
    chk(name, int'(b === 1'b0), 1);
  endtask

  initial begin
    logic ge, gu;
    int   lat, wid;

    // --- A: reset, correct code, 8-cycle unlock window
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    code4(1, 2, 3, 4, 1, 0);
    idl(8, 1, 0, 0, 1, 0);
    idl(1, 0, 0, 0, 0, 0);
    // --- B: wrong code, then right code clears fail_cnt
    code4(1, 2, 3, 5, 0, 0);
    idl(1, 0, 0, 0, 0, 1);
    code4(1, 2, 3, 4, 1, 1);
    idl(8, 1, 0, 0, 1, 0);
    idl(1, 0, 0, 0, 0, 0);
    // --- C: three failures -> 16-cycle lockout, digits and clear ignored
    code4(1, 2, 3, 5, 0, 0); idl(1, 0, 0, 0, 0, 1);
    code4(1, 2, 3, 5, 0, 1); idl(1, 0, 0, 0, 0, 2);
    code4(1, 2, 3, 5, 0, 2);
    add(0, 1, 1, 0, 0, 0, 1, 1, 3);
    add(0, 1, 1, 0, 0, 0, 1, 1, 3);
    add(0, 1, 2, 0, 0, 0, 1, 1, 3);
    add(0, 1, 3, 0, 0, 0, 1, 1, 3);
    add(0, 1, 4, 0, 0, 0, 1, 1, 3);
    add(0, 0, 0, 1, 0, 0, 1, 1, 3);
    idl(10, 0, 0, 1, 1, 3);
    idl(1, 0, 0, 0, 0, 0);
    // --- D: clear with digit 3 aborts entry, fail_cnt kept; clear relocks OPEN
    code4(1, 2, 3, 5, 0, 0); idl(1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 2, 0, 0, 0, 0, 0, 1);
    add(0, 1, 3, 1, 0, 0, 0, 0, 1);
    code4(1, 2, 3, 4, 1, 1);
    idl(2, 1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // --- E: reset in 3rd OPEN cycle, and mid-lockout
    code4(1, 2, 3, 4, 1, 0);
    idl(3, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idl(1, 0, 0, 0, 0, 0);
    code4(1, 2, 3, 5, 0, 0); idl(1, 0, 0, 0, 0, 1);
    code4(1, 2, 3, 5, 0, 1); idl(1, 0, 0, 0, 0, 2);
    code4(1, 2, 3, 5, 0, 2);
    idl(3, 0, 0, 1, 1, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    code4(1, 2, 3, 4, 1, 0);
    idl(1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].r; dv = vq[i].dv; din = vq[i].d; clr = vq[i].c;
      step();
      n_vec++;
      if ({u, e, lo, b, f} !== vq[i].x) begin
        n_bad++;
        $display("FAIL vec%0d: got u,e,lo,busy,fail=%b required %b",
                 i, {u, e, lo, b, f}, vq[i].x);
      end
    end
    rst = 0; dv = 0; din = 0; clr = 0;

    // --- Hand sequence: unlock appears 2 cycles after digit 4 is presented
    rst = 1; step(); rst = 0;
    digit(1); digit(2); digit(3);
    dv = 1; din = 4;               // cycle 0: digit 4 presented
    step();
    dv = 0; din = 0;
    lat = 1;
    while (u !== 1'b1 && lat < 10) begin step(); lat++; end
    chk("unlock_latency", lat, 2);
    wid = 0;
    while (u === 1'b1 && wid < 40) begin wid++; step(); end
    chk("unlock_width", wid, 8);
    chk("fail_after_open", int'(f), 0);
    chk("busy_after_open", int'(b), 0);

`ifdef LOCK_CODE_PROG_EN
    // --- Programming: ignored in IDLE, taken in OPEN
    rst = 1; step(); rst = 0;
    pv = 1; pc = 16'h5555; step(); pv = 0;
    run_code(1, 2, 3, 4, ge, gu);
    chk("prog_idle_ignored_unlock", int'(gu), 1);
    pv = 1; pc = 16'h9876; step(); pv = 0;
    wait_idle("prog_wait_open_end");
    run_code(1, 2, 3, 4, ge, gu);
    chk("old_code_error", int'(ge), 1);
    chk("old_code_no_unlock", int'(gu), 0);
    wait_idle("prog_wait_idle");
    run_code(9, 8, 7, 6, ge, gu);
    chk("new_code_no_error", int'(ge), 0);
    chk("new_code_unlock", int'(gu), 1);
    wait_idle("prog_wait_final");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
